// File: rtl/frog_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frog_pkg
//  Purpose  : Shared game constants for the frogger controller, lane
//             generator and VGA renderer.
//  Revision : 1.0  initial release
// ============================================================================
package frog_pkg;

    // Game-state encoding as seen on the game_state output
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_DEAD = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } game_state_e;

    localparam logic [2:0] START_ROW = 3'd7;
    localparam logic [7:0] START_COL = 8'b0001_0000;
    // Bit n set means row n is a car-free verge
    localparam logic [7:0] SAFE_ROWS = 8'b1001_0001;

    // Bit positions of the buttons inside the press vector
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_START = 4;
    localparam int NUM_BTNS  = 5;

    function automatic logic row_is_safe(input logic [2:0] row);
        return SAFE_ROWS[row];
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Synchronises one raw active-low button, filters bounce and
//             emits a single-cycle pulse on each accepted press.
//  Revision : 1.0  initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic pressed_o
);

    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          pressed_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser; idle level of a released button is 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples; pulse on accepted press
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q   <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            pressed_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q     <= '0;
                level_q   <= sync2_q;
                pressed_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign pressed_o = pressed_q;

endmodule
`default_nettype wire

// File: rtl/frog_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frog_game_ctrl
//  Purpose  : Frogger game sequencer: button debouncing, frog position,
//             lives/score, lane tick generation and game state machine.
//  Revision : 1.0  initial release
// ============================================================================
module frog_game_ctrl
    import frog_pkg::*;
#(
    parameter int TICK_PERIOD     = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEAD_HOLD       = 50_000_000,
    parameter int LIVES           = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_up_n_i,
    input  logic       btn_down_n_i,
    input  logic       btn_left_n_i,
    input  logic       btn_right_n_i,
    input  logic       btn_start_n_i,
    input  logic [7:0] lane_occ_i,
    output logic [2:0] frog_row_o,
    output logic [7:0] frog_col_o,
    output logic       lane_tick_o,
    output logic [2:0] game_state_o,
    output logic [1:0] lives_o,
    output logic [7:0] score_o
);

    localparam int            TW         = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_PERIOD - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    localparam int            HW         = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(DEAD_HOLD - 1);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    game_state_e   state_q;
    logic [2:0]    row_q;
    logic [7:0]    col_q;
    logic [1:0]    lives_q;
    logic [7:0]    score_q;
    logic [HW-1:0] hold_q;
    logic [TW-1:0] tick_cnt_q;

    logic [NUM_BTNS-1:0] w_btn_n;
    logic [NUM_BTNS-1:0] w_press;
    logic [2:0]          w_row_d;
    logic [7:0]          w_col_d;
    logic                w_hit;
    logic                w_tick_run;

    assign w_btn_n = {btn_start_n_i, btn_right_n_i, btn_left_n_i, btn_down_n_i, btn_up_n_i};

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .btn_n_i   (w_btn_n[gi]),
            .pressed_o (w_press[gi])
        );
    end

    // Collision against the registered position; verge rows never kill
    assign w_hit = (|(lane_occ_i & col_q)) && !row_is_safe(row_q);

    // Candidate position from the highest-priority press, clamped at the board edges
    always_comb begin
        w_row_d = row_q;
        w_col_d = col_q;
        if (w_press[BTN_UP]) begin
            if (row_q != 3'd0) w_row_d = row_q - 3'd1;
        end else if (w_press[BTN_DOWN]) begin
            if (row_q != 3'd7) w_row_d = row_q + 3'd1;
        end else if (w_press[BTN_LEFT]) begin
            if (!col_q[7]) w_col_d = col_q << 1;
        end else if (w_press[BTN_RIGHT]) begin
            if (!col_q[0]) w_col_d = col_q >> 1;
        end
    end

    // Game state machine together with position, lives, score and death hold timer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            row_q   <= START_ROW;
            col_q   <= START_COL;
            lives_q <= LIVES_INIT;
            score_q <= 8'd0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_press[BTN_START]) state_q <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_hit) begin
                        // The move of this cycle is discarded
                        state_q <= ST_DEAD;
                        lives_q <= (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                        hold_q  <= '0;
                    end else if (row_q == 3'd0) begin
                        state_q <= ST_WIN;
                        score_q <= (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                    end else begin
                        row_q <= w_row_d;
                        col_q <= w_col_d;
                    end
                end
                ST_DEAD: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        if (lives_q == 2'd0) begin
                            // Position stays frozen at the crash site
                            state_q <= ST_OVER;
                        end else begin
                            state_q <= ST_PLAY;
                            row_q   <= START_ROW;
                            col_q   <= START_COL;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_ONE;
                    end
                end
                ST_WIN: begin
                    state_q <= ST_PLAY;
                    row_q   <= START_ROW;
                    col_q   <= START_COL;
                end
                ST_OVER: begin
                    if (w_press[BTN_START]) begin
                        state_q <= ST_PLAY;
                        lives_q <= LIVES_INIT;
                        score_q <= 8'd0;
                        row_q   <= START_ROW;
                        col_q   <= START_COL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign w_tick_run = (state_q == ST_PLAY) || (state_q == ST_DEAD) || (state_q == ST_WIN);

    // Lane tick divider, parked at zero whenever the game is not running
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= '0;
        end else if (!w_tick_run || (tick_cnt_q == TICK_LAST)) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_ONE;
        end
    end

    // Decoded from registers only; gating with the state keeps OVER/IDLE tick-free
    assign lane_tick_o  = w_tick_run && (tick_cnt_q == TICK_LAST);
    assign frog_row_o   = row_q;
    assign frog_col_o   = col_q;
    assign game_state_o = state_q;
    assign lives_o      = lives_q;
    assign score_o      = score_q;

endmodule
`default_nettype wire

// File: tb/tb_frog_game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_frog_game_ctrl
//  Purpose  : Self-checking bench for frog_game_ctrl with a position/lives/
//             score reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frog_game_ctrl;

    localparam int TICK_PERIOD = 8;
    localparam int DEB         = 4;
    localparam int DEAD_HOLD   = 16;
    localparam int LIVES       = 3;
    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, START = 4;
    localparam int S_IDLE = 0, S_PLAY = 1, S_DEAD = 2, S_WIN = 3, S_OVER = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn_n = 5'b11111;
    logic [7:0] lane_occ = 8'h00;
    logic [2:0] frog_row;
    logic [7:0] frog_col;
    logic       lane_tick;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;
    int win_cycles = 0;
    int tick_count = 0;
    int start_pulses = 0;

    // Reference model: row 0..7, column index 0..7 (bit position, 7 = leftmost)
    int m_row, m_col, m_lives, m_score, m_state;

    frog_game_ctrl #(
        .TICK_PERIOD     (TICK_PERIOD),
        .DEBOUNCE_CYCLES (DEB),
        .DEAD_HOLD       (DEAD_HOLD),
        .LIVES           (LIVES)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .btn_up_n_i    (btn_n[UP]),
        .btn_down_n_i  (btn_n[DOWN]),
        .btn_left_n_i  (btn_n[LEFT]),
        .btn_right_n_i (btn_n[RIGHT]),
        .btn_start_n_i (btn_n[START]),
        .lane_occ_i    (lane_occ),
        .frog_row_o    (frog_row),
        .frog_col_o    (frog_col),
        .lane_tick_o   (lane_tick),
        .game_state_o  (game_state),
        .lives_o       (lives),
        .score_o       (score)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (game_state == 3'd3) win_cycles++;
        if (lane_tick) tick_count++;
        if (dut.w_press[START]) start_pulses++;
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold long enough for sync + debounce, then release long enough to re-arm
    task automatic press(input logic [4:0] mask);
        btn_n = ~mask;
        step(8);
        btn_n = 5'b11111;
        step(8);
    endtask

    function automatic logic [7:0] onehot(input int idx);
        logic [7:0] v;
        v = 8'd1 << idx;
        return v;
    endfunction

    task automatic model_move(input int b);
        case (b)
            UP:      if (m_row > 0) m_row--;
            DOWN:    if (m_row < 7) m_row++;
            LEFT:    if (m_col < 7) m_col++;
            RIGHT:   if (m_col > 0) m_col--;
            default: ;
        endcase
        if (m_row == 0) begin
            if (m_score < 255) m_score++;
            m_row = 7;
            m_col = 4;
        end
    endtask

    task automatic move(input int b);
        press(5'd1 << b);
        model_move(b);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_state"}, game_state, m_state);
        chk({tag, "_row"},   frog_row,   m_row);
        chk({tag, "_col"},   frog_col,   onehot(m_col));
        chk({tag, "_lives"}, lives,      m_lives);
        chk({tag, "_score"}, score,      m_score);
    endtask

    function automatic bit model_hit(input logic [7:0] occ);
        return (occ[m_col] == 1'b1) && (m_row != 0) && (m_row != 4) && (m_row != 7);
    endfunction

    // Kill the frog at its current (unsafe) square and wait out the hold time
    task automatic kill_frog(input string tag);
        lane_occ = 8'($urandom) | onehot(m_col);
        step(1);
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_state = S_DEAD;
        chk_all({tag, "_dead"});
        lane_occ = 8'h00;
        step(DEAD_HOLD);
        if (m_lives == 0) begin
            m_state = S_OVER;
        end else begin
            m_state = S_PLAY;
            m_row = 7;
            m_col = 4;
        end
        chk_all({tag, "_after"});
    endtask

    initial begin
        int n, t0, w0;
        int r;
        logic [7:0] occ;
        bit hit;

        m_row = 7; m_col = 4; m_lives = LIVES; m_score = 0; m_state = S_IDLE;

        // 1: reset, idle with no buttons
        step(3);
        rst_n = 1'b1;
        chk_all("reset");
        chk("reset_tick", lane_tick, 1'b0);
        step(100);
        chk("idle_ticks", tick_count, 0);
        chk_all("idle");

        // 2: start held 10 cycles -> one pulse, PLAY
        btn_n[START] = 1'b0;
        step(10);
        btn_n[START] = 1'b1;
        step(10);
        chk("start_pulses", start_pulses, 1);
        m_state = S_PLAY;
        chk_all("start");

        n = 0;
        while (!lane_tick && n < 20) begin step(1); n++; end
        chk("tick_seen", lane_tick, 1'b1);
        n = 0;
        do begin step(1); n++; end while (!lane_tick && n < 20);
        chk("tick_interval", n, TICK_PERIOD);
        step(1);
        chk("tick_width", lane_tick, 1'b0);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (lane_tick) n++;
            step(1);
        end
        chk("tick_count64", n, 64 / TICK_PERIOD);

        btn_n[UP] = 1'b0;
        step(2);
        btn_n[UP] = 1'b1;
        step(20);
        chk_all("glitch");

        // 3: left to the edge, then up+right together
        for (int i = 0; i < 4; i++) begin
            move(LEFT);
            chk_all($sformatf("left%0d", i));
        end
        press((5'd1 << UP) | (5'd1 << RIGHT));
        model_move(UP);
        chk_all("up_right");

        // 4: cross to row 0 -> single WIN cycle
        w0 = win_cycles;
        for (int i = 0; i < 6; i++) move(UP);
        chk("win_len", win_cycles - w0, 1);
        chk_all("win1");

        w0 = win_cycles;
        for (int k = 0; k < 254; k++)
            for (int i = 0; i < 7; i++) move(UP);
        chk("win_many", win_cycles - w0, 254);
        chk_all("score255");
        for (int i = 0; i < 7; i++) move(UP);
        chk_all("score_sat");

        // 5: death at row 3, moves ignored while dead
        for (int i = 0; i < 4; i++) move(UP);
        chk_all("row3");
        lane_occ = 8'h10;
        step(1);
        m_lives = 2;
        m_state = S_DEAD;
        chk_all("dead3");
        btn_n[LEFT] = 1'b0;
        step(8);
        btn_n[LEFT] = 1'b1;
        step(6);
        chk_all("dead_frozen");
        step(1);
        chk("dead_last", game_state, S_DEAD);
        step(1);
        m_state = S_PLAY; m_row = 7; m_col = 4;
        chk_all("respawn");
        lane_occ = 8'h00;

        for (int i = 0; i < 3; i++) move(UP);
        lane_occ = 8'h10;
        step(3);
        chk_all("safe_row4");
        lane_occ = 8'h00;

        // 6: lose the remaining lives, game over, restart
        move(UP);
        kill_frog("death2");
        move(UP);
        kill_frog("death3");
        t0 = tick_count;
        move(LEFT);
        model_move(-1);
        m_col = 4;
        step(24);
        chk("over_ticks", tick_count - t0, 0);
        chk_all("over_hold");
        press(5'd1 << START);
        m_state = S_PLAY; m_lives = LIVES; m_score = 0; m_row = 7; m_col = 4;
        chk_all("restart");

        // Randomised play against the model
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 5);
            if (r < 4) begin
                move(r);
                chk_all($sformatf("rnd_mv%0d", it));
            end else if (r == 4) begin
                press(5'd1 << START);
                chk_all($sformatf("rnd_start%0d", it));
            end else begin
                occ = 8'($urandom_range(1, 255));
                hit = model_hit(occ);
                lane_occ = occ;
                step(1);
                lane_occ = 8'h00;
                if (hit) begin
                    m_lives--;
                    m_state = S_DEAD;
                    chk_all($sformatf("rnd_hit%0d", it));
                    step(DEAD_HOLD);
                    if (m_lives == 0) begin
                        m_state = S_OVER;
                        chk_all($sformatf("rnd_over%0d", it));
                        press(5'd1 << START);
                        m_lives = LIVES; m_score = 0;
                    end
                    m_state = S_PLAY; m_row = 7; m_col = 4;
                end
                chk_all($sformatf("rnd_occ%0d", it));
            end
        end

        // Reset asserted in the middle of DEAD
        if (m_row == 7 || m_row == 4) move(UP);
        lane_occ = onehot(m_col);
        step(1);
        lane_occ = 8'h00;
        chk("pre_rst_dead", game_state, S_DEAD);
        step(5);
        #2 rst_n = 1'b0;
        #1;
        m_state = S_IDLE; m_row = 7; m_col = 4; m_lives = LIVES; m_score = 0;
        chk_all("async_rst");
        chk("async_rst_tick", lane_tick, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(20);
        chk_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
